sram_port_arbiter: RTL and testbench

- Two-port arbiter that shares the single SRAM control request interface between requester 0 (AHB-Lite slave interface) and requester 1 (DMA/scrub engine).
- Sits between the requesters and the SRAM controller.
- Issues exactly one transaction at a time and returns each ack and read data to the requester that was granted.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_rr_pick.sv | 26 ++
 rtl/sram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM port arbiter
// Holds the arbiter FSM state encoding, default bus widths and HSIZE codes.
package sram_arb_pkg;

  localparam int unsigned SRAM_ARB_AW_DEFAULT = 20;
  localparam int unsigned SRAM_ARB_DW_DEFAULT = 32;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// rtl/sram_arb_rr_pick.sv - combinational two-way request picker
// Ports:
//   req[1:0]    requests from port 0 / port 1
//   last_grant  port that completed most recently
//   fixed_prio  1 = port 0 wins ties, 0 = port other than last_grant wins
//   valid       at least one request present
//   winner      selected port (meaningful only when valid)
module sram_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = fixed_prio ? 1'b0 : ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port arbiter in front of a single SRAM controller
// Serialises requester 0 (AHB-Lite slave side) and requester 1 (DMA/scrub)
// onto one SRAM request interface, one transaction at a time.
// Optional build macro: SRAM_ARB_TIMEOUT_EN (bounded WAIT with error report).
// Ports:
//   HCLK, HRESETN             clock, synchronous active-low reset
//   m0_*, m1_*                requester side: req/write/addr/wdata/size in,
//                             ack/rdata/err out (ack is a one-cycle pulse)
//   ahbsram_*                 registered request fields, ahbsram_req one-cycle pulse
//   sramahb_ack/sramahb_rdata controller completion pulse and read data
//   BUSY                      controller busy, blocks new grants only
//   grant_id                  port of the current or most recent grant
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW             = SRAM_ARB_AW_DEFAULT,
  parameter int DW             = SRAM_ARB_DW_DEFAULT,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          HCLK,
  input  logic          HRESETN,

  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_size,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_size,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,

  output logic          ahbsram_req,
  output logic          ahbsram_write,
  output logic [AW-1:0] ahbsram_addr,
  output logic [DW-1:0] ahbsram_wdata,
  output logic [2:0]    ahbsram_size,
  input  logic          sramahb_ack,
  input  logic [DW-1:0] sramahb_rdata,
  input  logic          BUSY,

  output logic          grant_id
);

  arb_state_e    state_q, state_d;
  logic          grant_id_q;
  logic          last_grant_q;
  logic [DW-1:0] rdata_q;
  logic          pick_valid;
  logic          pick_winner;
  logic          grant_now;
  logic          done_m0;
  logic          done_m1;

  sram_arb_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO != 0),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Requests are only looked at in IDLE; DONE always passes through IDLE
  // so a request held into the ack cycle cannot be granted twice.
  assign grant_now = (state_q == IDLE) && pick_valid && !BUSY;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt_q;
  logic          err_q;
  logic          timeout_hit;

  // Counter equals the number of WAIT cycles already spent, so the last
  // allowed WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign timeout_hit = (state_q == WAIT) && !sramahb_ack &&
                       (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ISSUE) begin
        wait_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (state_q == DONE) begin
        err_q <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (grant_now) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (sramahb_ack) begin
          state_d = DONE;
`ifdef SRAM_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q       <= IDLE;
      grant_id_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      rdata_q       <= '0;
      ahbsram_write <= 1'b0;
      ahbsram_addr  <= '0;
      ahbsram_wdata <= '0;
      ahbsram_size  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        grant_id_q    <= pick_winner;
        ahbsram_write <= pick_winner ? m1_write : m0_write;
        ahbsram_addr  <= pick_winner ? m1_addr  : m0_addr;
        ahbsram_wdata <= pick_winner ? m1_wdata : m0_wdata;
        ahbsram_size  <= pick_winner ? m1_size  : m0_size;
      end
      if ((state_q == WAIT) && sramahb_ack) begin
        rdata_q <= sramahb_rdata;
      end else if (state_q == DONE) begin
        rdata_q <= '0;
        last_grant_q <= grant_id_q;
      end
    end
  end

  assign ahbsram_req = (state_q == ISSUE);
  assign grant_id    = grant_id_q;

  assign done_m0  = (state_q == DONE) && !grant_id_q;
  assign done_m1  = (state_q == DONE) &&  grant_id_q;
  assign m0_ack   = done_m0;
  assign m1_ack   = done_m1;
  assign m0_rdata = done_m0 ? rdata_q : '0;
  assign m1_rdata = done_m1 ? rdata_q : '0;

`ifdef SRAM_ARB_TIMEOUT_EN
  assign m0_err = done_m0 & err_q;
  assign m1_err = done_m1 & err_q;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETN;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [2:0]    m0_size, m1_size;
  logic          sramahb_ack, BUSY;
  logic [DW-1:0] sramahb_rdata;

  logic          rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err, rr_req, rr_write, rr_gid;
  logic [DW-1:0] rr_m0_rdata, rr_m1_rdata, rr_wdata;
  logic [AW-1:0] rr_addr;
  logic [2:0]    rr_size;
  logic          fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_req, fp_write, fp_gid;
  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata, fp_wdata;
  logic [AW-1:0] fp_addr;
  logic [2:0]    fp_size;

  always #5 HCLK = ~HCLK;

  sram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_ack(rr_m0_ack), .m0_rdata(rr_m0_rdata), .m0_err(rr_m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_ack(rr_m1_ack), .m1_rdata(rr_m1_rdata), .m1_err(rr_m1_err),
    .ahbsram_req(rr_req), .ahbsram_write(rr_write), .ahbsram_addr(rr_addr),
    .ahbsram_wdata(rr_wdata), .ahbsram_size(rr_size),
    .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY), .grant_id(rr_gid)
  );

  sram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) dut_fp (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata), .m1_err(fp_m1_err),
    .ahbsram_req(fp_req), .ahbsram_write(fp_write), .ahbsram_addr(fp_addr),
    .ahbsram_wdata(fp_wdata), .ahbsram_size(fp_size),
    .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY), .grant_id(fp_gid)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        write;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int          delay;
    logic [31:0] ctrl_rdata;
    int          exp_ack_cycle;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rr_outs"}, {rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err, rr_req, rr_write, rr_gid,
                            |rr_m0_rdata, |rr_m1_rdata, |rr_wdata, |rr_addr, |rr_size}, 64'h0);
    chk({tag, "_fp_outs"}, {fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_req, fp_write, fp_gid,
                            |fp_m0_rdata, |fp_m1_rdata, |fp_wdata, |fp_addr, |fp_size}, 64'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int req_cnt = 0;
    int ack_cyc = -1;
    int other_bad = 0;
    if (v.port) begin
      m1_req = 1'b1; m1_write = v.write; m1_addr = v.addr; m1_wdata = v.wdata; m1_size = v.size;
    end else begin
      m0_req = 1'b1; m0_write = v.write; m0_addr = v.addr; m0_wdata = v.wdata; m0_size = v.size;
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rr_req) begin
        req_cnt++;
        if (c == 1) begin
          chk($sformatf("v%0d_addr", idx), rr_addr, v.addr);
          chk($sformatf("v%0d_write", idx), rr_write, v.write);
          chk($sformatf("v%0d_wdata", idx), rr_wdata, v.wdata);
          chk($sformatf("v%0d_size", idx), rr_size, v.size);
          chk($sformatf("v%0d_gid", idx), rr_gid, v.port);
        end
      end
      if (v.port ? (rr_m0_ack || rr_m0_rdata != 0) : (rr_m1_ack || rr_m1_rdata != 0)) other_bad++;
      if (v.port ? rr_m1_ack : rr_m0_ack) begin
        ack_cyc = c;
        chk($sformatf("v%0d_rdata", idx), v.port ? rr_m1_rdata : rr_m0_rdata, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), v.port ? rr_m1_err : rr_m0_err, 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        sramahb_ack = 1'b0;
        break;
      end
      sramahb_ack   = (c == 1 + v.delay);
      sramahb_rdata = (c == 1 + v.delay) ? v.ctrl_rdata : 32'h0BAD0BAD;
    end
    chk($sformatf("v%0d_ack_cycle", idx), ack_cyc, v.exp_ack_cycle);
    chk($sformatf("v%0d_req_pulses", idx), req_cnt, 1);
    chk($sformatf("v%0d_other_port", idx), other_bad, 0);
    tick();
    chk($sformatf("v%0d_rdata_after", idx), v.port ? rr_m1_rdata : rr_m0_rdata, 32'h0);
  endtask

  initial begin
    int n_rr, n_fp, req_first, req_cnt, ack_cyc, bad;
    logic [19:0] rr_exp_addr [4];
    rr_exp_addr[0] = 20'h10; rr_exp_addr[1] = 20'h20; rr_exp_addr[2] = 20'h10; rr_exp_addr[3] = 20'h20;

    vecs[0] = '{1'b0, 1'b0, 20'h00100, 32'h0, HSIZE_WORD, 2, 32'hDEADBEEF, 4, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 20'h0ABCD, 32'h0, HSIZE_HALF, 1, 32'h12345678, 3, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 20'h00040, 32'hCAFEF00D, HSIZE_BYTE, 3, 32'h0, 5, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 20'hFFFFC, 32'hA5A5A5A5, HSIZE_WORD, 1, 32'h0, 3, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 20'h01234, 32'h0, HSIZE_WORD, 5, 32'h0F0F0F0F, 7, 32'h0F0F0F0F};

    HRESETN = 1'b0; BUSY = 1'b0; sramahb_ack = 1'b0; sramahb_rdata = '0;
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_size = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_size = '0;
    tick(); tick();
    HRESETN = 1'b1;
    chk_all_zero("reset");

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Both ports hold writes, controller acks at the first WAIT cycle.
    sramahb_ack = 1'b1; sramahb_rdata = 32'h77;
    m0_req = 1; m0_write = 1; m0_addr = 20'h10; m0_wdata = 32'h11111111; m0_size = HSIZE_WORD;
    m1_req = 1; m1_write = 1; m1_addr = 20'h20; m1_wdata = 32'h22222222; m1_size = HSIZE_WORD;
    n_rr = 0; n_fp = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (rr_req) begin
        if (n_rr < 4) begin
          chk($sformatf("rr%0d_addr", n_rr), rr_addr, rr_exp_addr[n_rr]);
          chk($sformatf("rr%0d_gid", n_rr), rr_gid, n_rr % 2);
          chk($sformatf("rr%0d_cycle", n_rr), c, 1 + 4 * n_rr);
        end
        n_rr++;
      end
      if (fp_req) begin
        chk($sformatf("fp%0d_addr", n_fp), fp_addr, 20'h10);
        chk($sformatf("fp%0d_gid", n_fp), fp_gid, 1'b0);
        n_fp++;
      end
    end
    chk("rr_grant_count", n_rr, 4);
    chk("fp_grant_count", n_fp, 4);
    m0_req = 0; m1_req = 0; sramahb_ack = 0;
    tick();

    // BUSY held high for cycles 0..4 while m1 requests; raised again in ISSUE.
    BUSY = 1; m1_req = 1; m1_write = 0; m1_addr = 20'h33333; m1_size = HSIZE_BYTE;
    req_first = -1; req_cnt = 0; ack_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (rr_req) begin
        req_cnt++;
        if (req_first < 0) req_first = c;
      end
      if (rr_m1_ack) begin
        ack_cyc = c;
        chk("busy_rdata", rr_m1_rdata, 32'h13572468);
        m1_req = 0;
      end
      if (c == 5) BUSY = 0;
      if (c == 6) BUSY = 1;
      sramahb_ack = (c == 7);
      sramahb_rdata = (c == 7) ? 32'h13572468 : 32'h0;
    end
    chk("busy_req_cycle", req_first, 6);
    chk("busy_req_count", req_cnt, 1);
    chk("busy_ack_cycle", ack_cyc, 8);
    BUSY = 0; m1_req = 0; sramahb_ack = 0;
    tick();

    // Reset pulse in WAIT followed by a stray controller ack.
    m0_req = 1; m0_write = 0; m0_addr = 20'h00200; m0_size = HSIZE_WORD;
    tick(); tick(); tick();
    HRESETN = 0; m0_req = 0; sramahb_rdata = 32'hFEEDFACE;
    tick();
    HRESETN = 1; sramahb_ack = 1;
    chk_all_zero("mid_reset");
    bad = 0;
    for (int c = 5; c <= 8; c++) begin
      tick();
      sramahb_ack = 0;
      if (rr_m0_ack || rr_m1_ack || rr_req || fp_m0_ack || fp_m1_ack || fp_req) bad++;
    end
    chk("after_reset_quiet", bad, 0);

    // Tie straight after reset goes to port 0; an ack during ISSUE is ignored.
    m0_req = 1; m0_write = 0; m0_addr = 20'h00300; m0_size = HSIZE_WORD;
    m1_req = 1; m1_write = 0; m1_addr = 20'h00400; m1_size = HSIZE_WORD;
    tick();
    chk("tie_req", rr_req, 1'b1);
    chk("tie_gid", rr_gid, 1'b0);
    chk("tie_addr", rr_addr, 20'h00300);
    sramahb_ack = 1; sramahb_rdata = 32'h99999999;
    tick();
    sramahb_ack = 0;
    bad = rr_m0_ack;
    tick();
    bad += rr_m0_ack;
    sramahb_ack = 1; sramahb_rdata = 32'hABCD0123;
    tick();
    sramahb_ack = 0;
    chk("issue_ack_ignored", bad, 0);
    chk("tie_m0_ack", rr_m0_ack, 1'b1);
    chk("tie_m0_rdata", rr_m0_rdata, 32'hABCD0123);
    chk("tie_m1_ack", rr_m1_ack, 1'b0);
    m0_req = 0; m1_req = 0;
    tick();

    // No controller ack for an m1 read.
    m1_req = 1; m1_write = 0; m1_addr = 20'h00500; m1_size = HSIZE_WORD;
    sramahb_rdata = 32'h5A5A5A5A;
    ack_cyc = -1; bad = 0;
`ifdef SRAM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      tick();
      sramahb_ack = 0;
      if (rr_m1_ack) begin
        if (ack_cyc < 0) begin
          ack_cyc = c;
          chk("to_err", rr_m1_err, 1'b1);
          chk("to_rdata", rr_m1_rdata, 32'h0);
        end else begin
          bad++;
        end
        m1_req = 0;
      end
      if (c == 11) sramahb_ack = 1;
    end
    chk("to_ack_cycle", ack_cyc, 10);
    chk("to_late_ack_ignored", bad, 0);
`else
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rr_m1_ack || rr_req != (c == 1)) bad++;
    end
    chk("no_to_stays_wait", bad, 0);
    sramahb_ack = 1; sramahb_rdata = 32'h600D600D;
    tick();
    sramahb_ack = 0;
    chk("no_to_ack", rr_m1_ack, 1'b1);
    chk("no_to_err", rr_m1_err, 1'b0);
    chk("no_to_rdata", rr_m1_rdata, 32'h600D600D);
    m1_req = 0;
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
